// File: rtl/fmc_slave_bridge.sv
// fmc_slave_bridge: asynchronous FMC/FSMC slave port bridged onto a simple
// valid/ready request bus with a separate read-response channel.
//
// Ports
//   clk, reset            single clock, asynchronous active-low reset
//   fmc_a, fmc_ne[],      FMC address, active-low chip selects,
//   fmc_noe, fmc_nwe      output-enable and write-enable strobes
//   fmc_d_in/out, fmc_d_oe  data pad in/out and tri-state enable
//   fmc_nwait             low while the bus transaction is outstanding
//   bus_*                 request (valid/ready) and response (rvalid/rdata)
//   txn_count, err_count, timeout_count   saturating 16-bit statistics
//
// Build option: FMC_BRIDGE_STATS_EN enables the statistics counters; without
// it the counter outputs are tied to zero.
//
// state     | meaning
// IDLE      | waiting for a single-chip-select read or write strobe
// ISSUE     | bus_valid held until bus_ready (or timeout)
// WAIT_RESP | read issued, waiting for bus_rvalid (or timeout)
// DRIVE     | read data on fmc_d_out, driven while noe/ne are low
// RELEASE   | write done, waiting for all chip selects to go high

module fmc_slave_bridge #(
    parameter int ADDR_BITS      = 26,
    parameter int DATA_BITS      = 32,
    parameter int NUM_CS         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_BITS      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] fmc_a,
    input  logic [NUM_CS-1:0]    fmc_ne,
    input  logic                 fmc_noe,
    input  logic                 fmc_nwe,
    input  logic [DATA_BITS-1:0] fmc_d_in,
    output logic [DATA_BITS-1:0] fmc_d_out,
    output logic                 fmc_d_oe,
    output logic                 fmc_nwait,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_we,
    output logic [SEL_BITS-1:0]  bus_sel,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_wdata,
    input  logic                 bus_rvalid,
    input  logic [DATA_BITS-1:0] bus_rdata,
    output logic [15:0]          txn_count,
    output logic [15:0]          err_count,
    output logic [15:0]          timeout_count
);

    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, DRIVE, RELEASE} state_t;

    state_t state, state_n;

    logic [NUM_CS-1:0]      ne_pipe [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] noe_pipe, nwe_pipe, prime_q;
    logic [NUM_CS-1:0]      ne_s;
    logic                   noe_s, nwe_s, flushed;

    logic [2:0]             low_cnt;
    logic [SEL_BITS-1:0]    cs_idx;
    logic                   all_high, start_ok, start_err;
    logic                   armed_q, abort_q, gone;
    logic [TMR_BITS-1:0]    tmr_q;
    logic                   tmr_zero;
    logic                   capture, lat_rd, lat_to;

    // Synchronisers reset to "released"; prime_q marks when the pipes hold
    // real pin samples so a cycle in progress at reset release is not
    // mistaken for an idle bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) ne_pipe[i] <= '1;
            noe_pipe <= '1;
            nwe_pipe <= '1;
            prime_q  <= '0;
        end else begin
            ne_pipe[0] <= fmc_ne;
            for (int i = 1; i < SYNC_STAGES; i++) ne_pipe[i] <= ne_pipe[i-1];
            noe_pipe <= {noe_pipe[SYNC_STAGES-2:0], fmc_noe};
            nwe_pipe <= {nwe_pipe[SYNC_STAGES-2:0], fmc_nwe};
            prime_q  <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ne_s    = ne_pipe[SYNC_STAGES-1];
    assign noe_s   = noe_pipe[SYNC_STAGES-1];
    assign nwe_s   = nwe_pipe[SYNC_STAGES-1];
    assign flushed = prime_q[SYNC_STAGES-1];

    always_comb begin
        low_cnt = '0;
        cs_idx  = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!ne_s[i]) begin
                low_cnt = low_cnt + 3'd1;
                cs_idx  = SEL_BITS'(i);
            end
        end
    end

    assign all_high  = &ne_s;
    assign start_ok  = armed_q && (low_cnt == 3'd1) && (noe_s ^ nwe_s);
    assign start_err = armed_q && (low_cnt != 3'd0) && (!noe_s || !nwe_s) &&
                       ((low_cnt > 3'd1) || (!noe_s && !nwe_s));
    assign tmr_zero  = (tmr_q == '0);
    assign gone      = abort_q || ne_s[bus_sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        lat_rd  = 1'b0;
        lat_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    capture = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_ready) begin
                    if (!bus_we)   state_n = WAIT_RESP;
                    else if (gone) state_n = IDLE;
                    else           state_n = RELEASE;
                end else if (tmr_zero) begin
                    if (gone)        state_n = IDLE;
                    else if (bus_we) state_n = RELEASE;
                    else begin
                        lat_to  = 1'b1;
                        state_n = DRIVE;
                    end
                end
            end
            WAIT_RESP: begin
                if (bus_rvalid || tmr_zero) begin
                    if (gone) state_n = IDLE;
                    else begin
                        lat_rd  = bus_rvalid;
                        lat_to  = !bus_rvalid;
                        state_n = DRIVE;
                    end
                end
            end
            DRIVE, RELEASE: begin
                if (all_high) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q   <= 1'b0;
            abort_q   <= 1'b0;
            tmr_q     <= '0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            fmc_d_out <= '0;
        end else begin
            if (capture || (state == IDLE && start_err)) armed_q <= 1'b0;
            else if (flushed && all_high)                armed_q <= 1'b1;

            if (capture) begin
                abort_q  <= 1'b0;
                tmr_q    <= TMR_BITS'(TIMEOUT_CYCLES - 1);
                bus_we   <= nwe_s ? 1'b0 : 1'b1;
                bus_sel  <= cs_idx;
                bus_addr <= fmc_a;
                if (!nwe_s) bus_wdata <= fmc_d_in;
            end else if (state == ISSUE || state == WAIT_RESP) begin
                if (ne_s[bus_sel]) abort_q <= 1'b1;
                if (!tmr_zero)     tmr_q   <= tmr_q - 1'b1;
            end

            if (lat_rd)      fmc_d_out <= bus_rdata;
            else if (lat_to) fmc_d_out <= '1;
        end
    end

    assign bus_valid = (state == ISSUE);
    assign fmc_nwait = !(state == ISSUE || state == WAIT_RESP);
    assign fmc_d_oe  = (state == DRIVE) && !noe_s && !ne_s[bus_sel];

`ifdef FMC_BRIDGE_STATS_EN
    logic        inc_err, inc_to, inc_txn;
    logic [15:0] txn_q, err_q, to_q;

    assign inc_err = (state == IDLE) && start_err;
    assign inc_to  = tmr_zero && (((state == ISSUE) && !bus_ready) ||
                                  ((state == WAIT_RESP) && !bus_rvalid));
    assign inc_txn = (state == DRIVE || state == RELEASE) && all_high;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_q <= '0;
            err_q <= '0;
            to_q  <= '0;
        end else begin
            if (inc_txn && txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
            if (inc_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (inc_to  && to_q  != 16'hFFFF) to_q  <= to_q  + 16'd1;
        end
    end

    assign txn_count     = txn_q;
    assign err_count     = err_q;
    assign timeout_count = to_q;
`else
    assign txn_count     = '0;
    assign err_count     = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_fmc_slave_bridge.sv
module tb_fmc_slave_bridge;

`ifdef FMC_BRIDGE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] fmc_a;
    logic [1:0]  fmc_ne;
    logic        fmc_noe, fmc_nwe;
    logic [31:0] fmc_d_in, fmc_d_out;
    logic        fmc_d_oe, fmc_nwait;
    logic        bus_valid, bus_ready, bus_we;
    logic [0:0]  bus_sel;
    logic [25:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [15:0] txn_count, err_count, timeout_count;

    int n_checks = 0;
    int n_fail   = 0;

    fmc_slave_bridge #(
        .ADDR_BITS(26), .DATA_BITS(32), .NUM_CS(2),
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .fmc_a(fmc_a), .fmc_ne(fmc_ne), .fmc_noe(fmc_noe), .fmc_nwe(fmc_nwe),
        .fmc_d_in(fmc_d_in), .fmc_d_out(fmc_d_out), .fmc_d_oe(fmc_d_oe),
        .fmc_nwait(fmc_nwait),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .txn_count(txn_count), .err_count(err_count),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Bus-side monitor: counts valid cycles and handshakes, captures fields.
    int          vcyc   = 0;
    int          hs_cnt = 0;
    logic        cap_we = 1'b0;
    logic [0:0]  cap_sel = '0;
    logic [25:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;

    always @(posedge clk) begin
        if (bus_valid) vcyc++;
        if (bus_valid && bus_ready) begin
            hs_cnt++;
            cap_we    = bus_we;
            cap_sel   = bus_sel;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_nwait(input logic lvl, input int lim, output int cyc);
        cyc = 0;
        while (fmc_nwait !== lvl && cyc < lim) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_valid(input int lim);
        int c;
        c = 0;
        while (bus_valid !== 1'b1 && c < lim) begin
            step(1);
            c++;
        end
    endtask

    initial begin
        int cyc, lowc, vbase, hbase;

        reset = 1'b0;
        fmc_a = '0; fmc_ne = 2'b11; fmc_noe = 1'b1; fmc_nwe = 1'b1;
        fmc_d_in = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        step(3);

        // Reset state
        chk("rst_nwait", fmc_nwait, 1);
        chk("rst_d_oe", fmc_d_oe, 0);
        chk("rst_d_out", fmc_d_out, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_cnts", {txn_count, err_count, timeout_count}, 0);
        reset = 1'b1;
        step(4);

        // Write on ne[0]
        vbase = vcyc; hbase = hs_cnt;
        bus_ready = 1'b1;
        fmc_a = 26'h0000123; fmc_d_in = 32'hCAFEF00D;
        fmc_ne = 2'b10; fmc_nwe = 1'b0;
        wait_nwait(1'b0, 10, cyc);
        chk("wr_nwait_low", fmc_nwait, 0);
        wait_nwait(1'b1, 30, lowc);
        chk("wr_nwait_high", fmc_nwait, 1);
        chk("wr_nwait_low_cycles", lowc, 1);
        chk("wr_valid_cycles", vcyc - vbase, 1);
        chk("wr_handshakes", hs_cnt - hbase, 1);
        chk("wr_we", cap_we, 1);
        chk("wr_sel", cap_sel, 0);
        chk("wr_addr", cap_addr, 26'h0000123);
        chk("wr_wdata", cap_wdata, 32'hCAFEF00D);
        chk("wr_d_oe", fmc_d_oe, 0);
        fmc_nwe = 1'b1; fmc_ne = 2'b11;
        step(4);
        chk("wr_txn_count", txn_count, STATS ? 1 : 0);
        chk("wr_idle_valid", bus_valid, 0);

        // Read on ne[1], response 5 cycles after the handshake
        hbase = hs_cnt;
        fmc_a = 26'h0000040; fmc_ne = 2'b01; fmc_noe = 1'b0;
        wait_valid(10);
        chk("rd_valid", bus_valid, 1);
        chk("rd_nwait_issue", fmc_nwait, 0);
        step(1);
        chk("rd_nwait_wait", fmc_nwait, 0);
        chk("rd_d_oe_wait", fmc_d_oe, 0);
        step(4);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        step(1);
        bus_rvalid = 1'b0; bus_rdata = '0;
        chk("rd_nwait_drive", fmc_nwait, 1);
        chk("rd_d_out", fmc_d_out, 32'h12345678);
        chk("rd_d_oe_on", fmc_d_oe, 1);
        chk("rd_we", cap_we, 0);
        chk("rd_sel", cap_sel, 1);
        chk("rd_addr", cap_addr, 26'h0000040);
        chk("rd_handshakes", hs_cnt - hbase, 1);
        fmc_noe = 1'b1;
        step(3);
        chk("rd_d_oe_off", fmc_d_oe, 0);
        fmc_ne = 2'b11;
        step(4);
        chk("rd_txn_count", txn_count, STATS ? 2 : 0);

        // Read that times out (16 cycles)
        fmc_a = 26'h0000200; fmc_ne = 2'b10; fmc_noe = 1'b0;
        wait_nwait(1'b0, 10, cyc);
        chk("to_nwait_low", fmc_nwait, 0);
        wait_nwait(1'b1, 40, lowc);
        chk("to_nwait_high", fmc_nwait, 1);
        chk("to_cycles", lowc, 16);
        chk("to_d_out", fmc_d_out, 32'hFFFFFFFF);
        chk("to_d_oe", fmc_d_oe, 1);
        chk("to_count", timeout_count, STATS ? 1 : 0);
        fmc_noe = 1'b1; fmc_ne = 2'b11;
        step(4);
        chk("to_txn_count", txn_count, STATS ? 3 : 0);
        chk("to_idle_nwait", fmc_nwait, 1);

        // Early release during a read: handshake still completes, data dropped
        hbase = hs_cnt;
        bus_ready = 1'b0;
        fmc_a = 26'h0000300; fmc_ne = 2'b10; fmc_noe = 1'b0;
        wait_valid(10);
        fmc_ne = 2'b11; fmc_noe = 1'b1;
        step(4);
        chk("er_valid_held", bus_valid, 1);
        chk("er_addr_held", bus_addr, 26'h0000300);
        bus_ready = 1'b1;
        step(1);
        bus_rvalid = 1'b1; bus_rdata = 32'hAAAA5555;
        step(1);
        bus_rvalid = 1'b0; bus_rdata = '0;
        step(1);
        chk("er_handshakes", hs_cnt - hbase, 1);
        chk("er_nwait", fmc_nwait, 1);
        chk("er_d_out_kept", fmc_d_out, 32'hFFFFFFFF);
        chk("er_d_oe", fmc_d_oe, 0);
        chk("er_txn_count", txn_count, STATS ? 3 : 0);

        // Stray rvalid while idle is ignored
        bus_rvalid = 1'b1; bus_rdata = 32'h00000BAD;
        step(2);
        bus_rvalid = 1'b0; bus_rdata = '0;
        chk("stray_rvalid", fmc_d_out, 32'hFFFFFFFF);

        // Two illegal strobe events
        vbase = vcyc;
        fmc_ne = 2'b00; fmc_noe = 1'b0;
        step(6);
        fmc_ne = 2'b11; fmc_noe = 1'b1;
        step(4);
        fmc_ne = 2'b10; fmc_noe = 1'b0; fmc_nwe = 1'b0;
        step(6);
        fmc_ne = 2'b11; fmc_noe = 1'b1; fmc_nwe = 1'b1;
        step(4);
        chk("err_no_valid", vcyc - vbase, 0);
        chk("err_count", err_count, STATS ? 2 : 0);

        // Reset during WAIT_RESP, strobes held through reset release
        hbase = hs_cnt;
        fmc_a = 26'h0000055; fmc_ne = 2'b10; fmc_noe = 1'b0;
        wait_valid(10);
        step(2);
        chk("rs_nwait_wait", fmc_nwait, 0);
        reset = 1'b0;
        #1;
        chk("rs_nwait_async", fmc_nwait, 1);
        chk("rs_d_oe_async", fmc_d_oe, 0);
        chk("rs_valid_async", bus_valid, 0);
        step(2);
        reset = 1'b1;
        vbase = vcyc;
        step(8);
        chk("rs_no_restart", vcyc - vbase, 0);
        chk("rs_handshakes", hs_cnt - hbase, 1);
        chk("rs_cnts", {txn_count, err_count, timeout_count}, 0);
        fmc_ne = 2'b11; fmc_noe = 1'b1;
        step(4);

        // Fresh write after release, top address
        hbase = hs_cnt;
        fmc_a = 26'h3FFFFFF; fmc_d_in = 32'h0F0F1234;
        fmc_ne = 2'b10; fmc_nwe = 1'b0;
        wait_nwait(1'b0, 10, cyc);
        chk("pr_nwait_low", fmc_nwait, 0);
        wait_nwait(1'b1, 30, lowc);
        chk("pr_handshakes", hs_cnt - hbase, 1);
        chk("pr_addr", cap_addr, 26'h3FFFFFF);
        chk("pr_wdata", cap_wdata, 32'h0F0F1234);
        fmc_ne = 2'b11; fmc_nwe = 1'b1;
        step(4);
        chk("pr_txn_count", txn_count, STATS ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fmc_slave_bridge.md
FMC_SLAVE_BRIDGE -- requirements
Module: fmc_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 26: FMC address width.
REQ-002 SHALL have parameter DATA_BITS, default 32: FMC and bus data width.
REQ-003 SHALL have parameter NUM_CS, default 2 (legal range 1..4): number of chip-select channels.
REQ-004 SHALL have parameter SYNC_STAGES, default 2 (minimum 2): synchroniser depth for the strobes.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: bus response limit, in clk cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports fmc_a input ADDR_BITS; fmc_ne input NUM_CS (active-low chip selects); fmc_noe input 1; fmc_nwe input 1.
REQ-009 SHALL have ports fmc_d_in input DATA_BITS; fmc_d_out output DATA_BITS; fmc_d_oe output 1 (pad tri-state control); fmc_nwait output 1 (low = wait).
REQ-010 SHALL have ports bus_valid output 1; bus_ready input 1; bus_we output 1; bus_sel output clog2(NUM_CS) (minimum 1 bit); bus_addr output ADDR_BITS; bus_wdata output DATA_BITS.
REQ-011 SHALL have ports bus_rvalid input 1; bus_rdata input DATA_BITS.
REQ-012 SHALL have ports txn_count, err_count and timeout_count, each output 16 bits.

Function
REQ-013 SHALL pass fmc_ne, fmc_noe and fmc_nwe through SYNC_STAGES flops; all decisions SHALL use only the synchronised strobes.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP, DRIVE and RELEASE.
REQ-015 In IDLE, a start SHALL be exactly one synced ne low plus exactly one of synced noe/nwe low.
REQ-016 On a start, the next cycle SHALL capture fmc_a, fmc_d_in (write only), the cs index and the direction, drive fmc_nwait=0 and enter ISSUE.
REQ-017 A start-like condition with more than one ne low, or with noe and nwe both low, SHALL be ignored and increment err_count once per event; the FSM SHALL stay in IDLE until all ne are high.
REQ-018 In ISSUE, bus_valid SHALL be 1 with all bus_* fields stable until the cycle bus_ready=1.
REQ-019 After that cycle, a write SHALL go to RELEASE and a read SHALL go to WAIT_RESP.
REQ-020 In WAIT_RESP, bus_rvalid=1 SHALL latch bus_rdata into fmc_d_out and enter DRIVE.
REQ-021 The response timer SHALL count the cycles spent in ISSUE and WAIT_RESP. When it reaches TIMEOUT_CYCLES, bus_valid SHALL drop, timeout_count SHALL increment, fmc_d_out SHALL be all ones (read only), and the FSM SHALL enter DRIVE (read) or RELEASE (write).
REQ-022 In DRIVE and RELEASE, fmc_nwait SHALL be 1.
REQ-023 In DRIVE, fmc_d_oe SHALL be 1 while synced noe is low and the selected ne is low.
REQ-024 DRIVE and RELEASE SHALL return to IDLE when all synced ne are high; txn_count SHALL increment on that return.
REQ-025 If the strobes are released early (selected ne high while in ISSUE or WAIT_RESP), the bus handshake SHALL still complete or time out. Read data SHALL then be discarded and the FSM SHALL return to IDLE.
REQ-026 fmc_d_oe SHALL never be 1 outside DRIVE.
REQ-027 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-028 bus_rvalid outside WAIT_RESP SHALL be ignored.

Reset
REQ-029 While reset=0: state IDLE, fmc_nwait=1, fmc_d_oe=0, fmc_d_out=0, bus_valid=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, counters 0, synchroniser flops 1.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately, with no further bus_valid.
REQ-031 After reset deasserts, an FMC cycle already in progress SHALL not start a transaction until all ne have been seen high.

Configuration
REQ-032 With macro FMC_BRIDGE_STATS_EN defined, txn_count, err_count and timeout_count SHALL behave as in REQ-017, REQ-021, REQ-024 and REQ-027.
REQ-033 Without FMC_BRIDGE_STATS_EN, the three counter outputs SHALL be constant 0 and no counter registers SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-034 Write: ne[0]=0, nwe=0, a=26'h0000123, d=32'hCAFEF00D, bus_ready=1 -> one bus_valid pulse with bus_we=1, bus_sel=0, bus_addr=26'h0000123, bus_wdata=32'hCAFEF00D; fmc_nwait low then high; txn_count=1 after ne rises.
REQ-035 Read on ne[1], a=26'h0000040, bus_rvalid after 5 cycles with bus_rdata=32'h12345678 -> fmc_nwait low until DRIVE; fmc_d_out=32'h12345678 with fmc_d_oe=1 while noe low; fmc_d_oe=0 when noe rises.
REQ-036 Read with bus_ready=1 and bus_rvalid never asserted, TIMEOUT_CYCLES=16 -> fmc_d_out=32'hFFFFFFFF; timeout_count=1; FSM returns to IDLE.
REQ-037 ne=2'b00 with noe low, then a separate event with noe and nwe both low -> no bus_valid; err_count=2.
REQ-038 reset=0 asserted during WAIT_RESP -> fmc_nwait=1 and fmc_d_oe=0 at once; no transaction until ne goes high then low again after release.
REQ-039 Build without FMC_BRIDGE_STATS_EN and repeat REQ-034 -> bus behaviour identical; all counters read 0.
